// File: rtl/itcm_fetch_rsp_pkg.sv
// Shared constants and helpers for the ITCM instruction-fetch responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Optional feature macro: ITCM_ERR_EN (adds a per-response access-error bit).
package itcm_fetch_rsp_pkg;

   localparam int PC_SIZE        = 32;
   localparam int INSTR_SIZE     = 32;
   localparam int ITCM_AW_DFLT   = 10;
   localparam logic [PC_SIZE-1:0] ITCM_BASE_DFLT = '0;
   localparam int ITCM_RSP_DEPTH = 2;

   // Width of one buffered response: instruction, plus the error flag when enabled.
`ifdef ITCM_ERR_EN
   localparam int RSP_W = INSTR_SIZE + 1;
`else
   localparam int RSP_W = INSTR_SIZE;
`endif

   // A fetch is in error when it is not word aligned or falls outside the
   // 2**(aw+2)-byte window starting at base.
   function automatic logic pc_err(input logic [PC_SIZE-1:0] pc,
                                   input logic [PC_SIZE-1:0] base,
                                   input int                 aw);
      logic misaligned;
      logic outside;
      misaligned = (pc[1:0] != 2'b00);
      outside    = ((pc >> (aw + 2)) != (base >> (aw + 2)));
      return misaligned || outside;
   endfunction

endpackage

// File: rtl/itcm_fetch_rsp_fifo.sv
// 2-entry in-order response FIFO with push, pop and flush.
// Latency: an entry pushed on an edge is visible at the head the next cycle.
// Backpressure: full_o is pure register state; pushes while full and pops while empty are ignored.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push_i        push request (only honoured when not full)
//   push_dat_i    data to push
//   pop_i         pop request (only honoured when not empty)
//   flush_i       drop all stored entries; a same-edge push is kept, a same-edge pop is ignored
//   full_o        FIFO holds the maximum number of entries
//   vld_o         FIFO holds at least one entry
//   head_dat_o    oldest entry, forced to zero when empty
module itcm_rsp_fifo
   import itcm_fetch_rsp_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         full_o,
   output logic         vld_o,
   output logic [W-1:0] head_dat_o
);

   localparam logic [1:0] CNT_FULL = 2'(ITCM_RSP_DEPTH);

   logic [W-1:0] data_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         do_push;
   logic         do_pop;
   logic         wr_idx;

   assign do_push = push_i && (cnt_q != CNT_FULL);
   // A flush wins over a pop: the entry being popped is discarded anyway.
   assign do_pop  = pop_i && (cnt_q != 2'd0) && !flush_i;
   // After a flush the kept request lands in slot 0, matching the cleared pointers.
   assign wr_idx  = flush_i ? 1'b0 : wr_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = do_push;
         cnt_d    = {1'b0, do_push};
      end else begin
         if (do_push) wr_ptr_d = ~wr_ptr_q;
         if (do_pop)  rd_ptr_d = ~rd_ptr_q;
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload needs no reset: it is only observable while cnt_q != 0.
   always_ff @(posedge clk) begin
      if (do_push) data_q[wr_idx] <= push_dat_i;
   end

   assign full_o     = (cnt_q == CNT_FULL);
   assign vld_o      = (cnt_q != 2'd0);
   assign head_dat_o = vld_o ? data_q[rd_ptr_q] : '0;

endmodule

// File: rtl/itcm_fetch_rsp.sv
// ITCM responder for the IFU fetch protocol: word-addressed array, one 32-bit instruction per accepted fetch.
// Latency: 1 cycle from request accept to response valid; sustains one fetch per cycle.
// Backpressure: 2-entry response FIFO; ifu_req_ready drops only when full (registered, no comb path from rsp_ready).
//
// Optional feature macro: ITCM_ERR_EN adds ifu_rsp_err and flags misaligned / out-of-window fetches.
// Array contents are not reset; they are loaded through the ld_* port.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ifu_req_valid/ready/pc          fetch request handshake and byte address
//   ifu_rsp_valid/ready/instr       response handshake and instruction (0 when no response)
//   itcm_flush                      discard all buffered, unconsumed responses
//   ld_we/ld_addr/ld_wdata          preload write port (word address)
//   ifu_rsp_err                     (ITCM_ERR_EN only) response carries an access error
module itcm_fetch_rsp
   import itcm_fetch_rsp_pkg::*;
#(
   parameter int                 ITCM_AW   = ITCM_AW_DFLT,
   parameter logic [PC_SIZE-1:0] ITCM_BASE = ITCM_BASE_DFLT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [PC_SIZE-1:0]    ifu_req_pc,
   output logic                  ifu_rsp_valid,
   input  logic                  ifu_rsp_ready,
   output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
   input  logic                  itcm_flush,
   input  logic                  ld_we,
   input  logic [ITCM_AW-1:0]    ld_addr,
   input  logic [INSTR_SIZE-1:0] ld_wdata
`ifdef ITCM_ERR_EN
   ,
   output logic                  ifu_rsp_err
`endif
);

   logic [INSTR_SIZE-1:0] mem_q [2**ITCM_AW];
   logic [ITCM_AW-1:0]    rd_idx;
   logic [INSTR_SIZE-1:0] rd_dat;
   logic [RSP_W-1:0]      push_dat;
   logic [RSP_W-1:0]      head_dat;
   logic                  fifo_full;

   assign rd_idx = ifu_req_pc[ITCM_AW+1:2];
   // Combinational read sampled into the FIFO on the accept edge; a preload to
   // the same word on that edge lands afterwards, so the fetch sees old data.
   assign rd_dat = mem_q[rd_idx];

   always_ff @(posedge clk) begin
      if (ld_we) mem_q[ld_addr] <= ld_wdata;
   end

`ifdef ITCM_ERR_EN
   logic req_err;
   assign req_err       = pc_err(ifu_req_pc, ITCM_BASE, ITCM_AW);
   assign push_dat      = {req_err, (req_err ? '0 : rd_dat)};
   assign ifu_rsp_err   = head_dat[INSTR_SIZE];
   assign ifu_rsp_instr = head_dat[INSTR_SIZE-1:0];
`else
   // Byte offset and bits above the window are don't-care: the window aliases.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{ifu_req_pc[1:0], ifu_req_pc[PC_SIZE-1:ITCM_AW+2], ITCM_BASE};
   assign push_dat       = rd_dat;
   assign ifu_rsp_instr  = head_dat;
`endif

   itcm_rsp_fifo #(
      .W (RSP_W)
   ) u_rsp_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (ifu_req_valid),
      .push_dat_i (push_dat),
      .pop_i      (ifu_rsp_ready),
      .flush_i    (itcm_flush),
      .full_o     (fifo_full),
      .vld_o      (ifu_rsp_valid),
      .head_dat_o (head_dat)
   );

   assign ifu_req_ready = !fifo_full;

endmodule

// File: tb/tb_itcm_fetch_rsp.sv
// Self-checking bench for itcm_fetch_rsp: reset, directed vector table, corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_itcm_fetch_rsp;
   localparam int AW = 10;
   localparam logic [31:0] I0 = 32'h00000013;
   localparam logic [31:0] I1 = 32'h00100093;
   localparam logic [31:0] I2 = 32'h00200113;
   localparam logic [31:0] I3 = 32'h00300193;
   localparam logic [31:0] DB = 32'hDEADBEEF;

   logic          clk = 1'b0;
   logic          rst_n, req_valid, req_ready, rsp_valid, rsp_ready, flush, ld_we;
   logic [31:0]   req_pc, rsp_instr, ld_wdata;
   logic [AW-1:0] ld_addr;
`ifdef ITCM_ERR_EN
   logic          rsp_err;
`endif

   always #5 clk = ~clk;

   itcm_fetch_rsp #(.ITCM_AW(AW), .ITCM_BASE(32'h0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ifu_req_valid (req_valid),
      .ifu_req_ready (req_ready),
      .ifu_req_pc    (req_pc),
      .ifu_rsp_valid (rsp_valid),
      .ifu_rsp_ready (rsp_ready),
      .ifu_rsp_instr (rsp_instr),
      .itcm_flush    (flush),
      .ld_we         (ld_we),
      .ld_addr       (ld_addr),
      .ld_wdata      (ld_wdata)
`ifdef ITCM_ERR_EN
      ,
      .ifu_rsp_err   (rsp_err)
`endif
   );

   int n_vec = 0;
   int n_mis = 0;

   typedef struct {
      logic          vld;
      logic [31:0]   pc;
      logic          rrdy;
      logic          flush;
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic          e_rdy;
      logic          e_vld;
      logic [31:0]   e_instr;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] mdl_mem [16];
   logic [32:0] mdl_q[$];   // {err, instr} per expected response, oldest first

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_pc = '0; rsp_ready = 1'b0; flush = 1'b0;
      ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
   endtask

   task automatic add(input logic vld, input logic [31:0] pc, input logic rrdy, input logic fl,
                      input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                      input logic e_rdy, input logic e_vld, input logic [31:0] e_instr);
      vec_t v;
      v.vld = vld; v.pc = pc; v.rrdy = rrdy; v.flush = fl; v.we = we; v.addr = addr;
      v.wdata = wd; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_instr = e_instr;
      tbl.push_back(v);
   endtask

   initial begin
      // Each row: inputs for this cycle, and outputs expected from state before its edge.
      //  vld pc      rrdy fl we addr wdata   rdy vld instr
      add(1, 32'd0,  1, 0, 0, 0, 0,        1, 0, 0);   // back-to-back fetch
      add(1, 32'd4,  1, 0, 0, 0, 0,        1, 1, I0);
      add(1, 32'd8,  1, 0, 0, 0, 0,        1, 1, I1);
      add(1, 32'd12, 1, 0, 0, 0, 0,        1, 1, I2);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 1, I3);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 0, 0);
      add(1, 32'd0,  0, 0, 0, 0, 0,        1, 0, 0);   // back-pressure
      add(1, 32'd4,  0, 0, 0, 0, 0,        1, 1, I0);
      add(1, 32'd8,  0, 0, 0, 0, 0,        0, 1, I0);
      add(1, 32'd8,  0, 0, 0, 0, 0,        0, 1, I0);
      add(1, 32'd8,  1, 0, 0, 0, 0,        0, 1, I0);  // pop at full: bubble
      add(1, 32'd8,  1, 0, 0, 0, 0,        1, 1, I1);  // pc 8 accepted
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 1, I2);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 0, 0);
      add(1, 32'd0,  0, 0, 0, 0, 0,        1, 0, 0);   // flush while full
      add(1, 32'd4,  0, 0, 0, 0, 0,        1, 1, I0);
      add(1, 32'd12, 1, 1, 0, 0, 0,        0, 1, I0);  // not accepted (full), pop ignored
      add(0, 32'd0,  0, 0, 0, 0, 0,        1, 0, 0);
      add(1, 32'd0,  0, 0, 0, 0, 0,        1, 0, 0);
      add(1, 32'd12, 1, 1, 0, 0, 0,        1, 1, I0);  // flush + accept same edge
      add(0, 32'd0,  0, 0, 0, 0, 0,        1, 1, I3);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 1, I3);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 0, 0);
      add(1, 32'd4,  1, 0, 1, 1, DB,       1, 0, 0);   // preload + fetch same word
      add(1, 32'd4,  1, 0, 0, 0, 0,        1, 1, I1);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 1, DB);
      add(0, 32'd0,  1, 0, 0, 0, 0,        1, 0, 0);

      idle_inputs();
      rst_n = 1'b0;
      repeat (3) step();
      chk("reset req_ready", req_ready, 1);
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_instr", rsp_instr, 0);
`ifdef ITCM_ERR_EN
      chk("reset rsp_err", rsp_err, 0);
`endif
      rst_n = 1'b1;
      step();
      chk("post-reset req_ready", req_ready, 1);
      chk("post-reset rsp_valid", rsp_valid, 0);
      chk("post-reset rsp_instr", rsp_instr, 0);

      // Preload words 0..15: the four fixed instructions then random filler.
      for (int i = 0; i < 16; i++) begin
         case (i)
            0: mdl_mem[i] = I0;
            1: mdl_mem[i] = I1;
            2: mdl_mem[i] = I2;
            3: mdl_mem[i] = I3;
            default: mdl_mem[i] = $urandom;
         endcase
         ld_we = 1'b1; ld_addr = AW'(i); ld_wdata = mdl_mem[i];
         step();
      end
      idle_inputs();
      step();

      for (int r = 0; r < tbl.size(); r++) begin
         req_valid = tbl[r].vld; req_pc = tbl[r].pc; rsp_ready = tbl[r].rrdy;
         flush = tbl[r].flush; ld_we = tbl[r].we; ld_addr = tbl[r].addr; ld_wdata = tbl[r].wdata;
         chk($sformatf("tbl[%0d].req_ready", r), req_ready, tbl[r].e_rdy);
         chk($sformatf("tbl[%0d].rsp_valid", r), rsp_valid, tbl[r].e_vld);
         chk($sformatf("tbl[%0d].rsp_instr", r), rsp_instr, tbl[r].e_instr);
         step();
      end
      mdl_mem[1] = DB;
      idle_inputs();

`ifdef ITCM_ERR_EN
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_pc = 32'h2;
      step();
      chk("err misaligned rsp_err", rsp_err, 1);
      chk("err misaligned rsp_instr", rsp_instr, 0);
      req_pc = 32'h1 << (AW + 2);
      step();
      chk("err window rsp_err", rsp_err, 1);
      chk("err window rsp_instr", rsp_instr, 0);
      req_pc = 32'h0;
      step();
      chk("err ok rsp_err", rsp_err, 0);
      chk("err ok rsp_instr", rsp_instr, I0);
      req_valid = 1'b0;
      step();
      chk("err drain rsp_valid", rsp_valid, 0);
`else
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_pc = 32'h4002;
      step();
      chk("alias rsp_valid", rsp_valid, 1);
      chk("alias rsp_instr", rsp_instr, I0);
      req_valid = 1'b0;
      step();
      chk("alias drain rsp_valid", rsp_valid, 0);
`endif
      idle_inputs();

      // Randomized traffic against a queue model of the response stream.
      for (int c = 0; c < 3000; c++) begin
         logic [2:0]  hi;
         logic [1:0]  lo;
         logic [3:0]  idx;
         logic        acc, pop, e_err;
         logic [32:0] ent;
         rst_n     = ($urandom_range(0, 199) != 0);
         idx       = 4'($urandom_range(0, 15));
         hi        = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         lo        = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         req_valid = ($urandom_range(0, 3) != 0);
         req_pc    = (32'(hi) << (AW + 2)) | (32'(idx) << 2) | 32'(lo);
         rsp_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         ld_we     = rst_n && ($urandom_range(0, 4) == 0);
         ld_addr   = AW'($urandom_range(0, 15));
         ld_wdata  = $urandom;

         chk("rnd req_ready", req_ready, 32'(mdl_q.size() != 2));
         chk("rnd rsp_valid", rsp_valid, 32'(mdl_q.size() != 0));
         chk("rnd rsp_instr", rsp_instr, (mdl_q.size() != 0) ? mdl_q[0][31:0] : 32'h0);
`ifdef ITCM_ERR_EN
         chk("rnd rsp_err", rsp_err, (mdl_q.size() != 0) ? 32'(mdl_q[0][32]) : 32'h0);
         e_err = (hi != 0) || (lo != 0);
`else
         e_err = 1'b0;
`endif
         acc = req_valid && (mdl_q.size() != 2);
         pop = (mdl_q.size() != 0) && rsp_ready;
         ent = e_err ? {1'b1, 32'h0} : {1'b0, mdl_mem[idx]};
         if (!rst_n) begin
            mdl_q.delete();
         end else if (flush) begin
            mdl_q.delete();
            if (acc) mdl_q.push_back(ent);
         end else begin
            if (pop) void'(mdl_q.pop_front());
            if (acc) mdl_q.push_back(ent);
         end
         if (ld_we) mdl_mem[ld_addr[3:0]] = ld_wdata;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
